xgmii_pattern_checker: RTL and testbench



---
 rtl/xgmii_pattern_checker.sv | 115 +++++++++++
 tb/tb_xgmii_pattern_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xgmii_pattern_checker.sv
// xgmii_pattern_checker: aligns to a fixed XGMII test-pattern rotation, reports lock and counts mismatched words
module xgmii_pattern_checker #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int PATTERN_COUNT = 6,
  parameter logic [PATTERN_COUNT*DATA_WIDTH-1:0] PATTERNS = {
    64'h0707070707070707, 64'hFEFEFEFEFEFEFEFE, 64'hAAAAAAAAAAAAAAAA,
    64'h5555555555555555, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF},
  parameter int LOCK_COUNT    = 4,
  parameter int WINDOW        = 64,
  parameter int UNLOCK_ERRORS = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     enable,
  input  logic                     rx_block_lock,
  input  logic [DATA_WIDTH-1:0]    xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0]    xgmii_rxc,
  input  logic                     clear_count,
  output logic                     pattern_lock,
  output logic                     pattern_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [2:0]               expected_index
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int WW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(UNLOCK_ERRORS + 1);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t          state;
  logic [GW-1:0]   good_cnt;
  logic [WW-1:0]   win_cnt;
  logic [EW-1:0]   win_err, win_err_nxt;
  logic            valid, match, hit, win_wrap;
  logic [2:0]      hit_idx, hit_next, idx_next;
  logic [DATA_WIDTH-1:0] pat [PATTERN_COUNT];
  for (genvar g = 0; g < PATTERN_COUNT; g++) begin : g_pat
    assign pat[g] = PATTERNS[g*DATA_WIDTH +: DATA_WIDTH];
  end
  function automatic logic [2:0] wrap_inc(input logic [2:0] i);
    return (i == 3'(PATTERN_COUNT - 1)) ? 3'd0 : i + 3'd1;
  endfunction
  // Searching from the top down leaves the lowest matching index as the winner
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = PATTERN_COUNT - 1; k >= 0; k--)
      if (xgmii_rxc == '0 && xgmii_rxd == pat[k]) begin
        hit = 1'b1;
        hit_idx = 3'(k);
      end
  end
  assign valid       = enable && rx_block_lock;
  assign match       = xgmii_rxc == '0 && xgmii_rxd == pat[expected_index];
  assign hit_next    = wrap_inc(hit_idx);
  assign idx_next    = wrap_inc(expected_index);
  assign win_wrap    = win_cnt == WW'(WINDOW - 1);
  // The wrap word opens the new window, so its own mismatch lands there
  assign win_err_nxt = (win_wrap ? '0 : win_err) + (match ? EW'(0) : EW'(1));
  always_ff @(posedge rx_clk or negedge rx_rst_n)
    if (!rx_rst_n) begin
      state          <= SEARCH;
      good_cnt       <= '0;
      win_cnt        <= '0;
      win_err        <= '0;
      pattern_lock   <= 1'b0;
      pattern_error  <= 1'b0;
      error_count    <= '0;
      expected_index <= '0;
    end else begin
      pattern_error <= 1'b0;
      if (!valid) begin
        state        <= SEARCH;
        pattern_lock <= 1'b0;
        good_cnt     <= '0;
        win_cnt      <= '0;
        win_err      <= '0;
      end else begin
        case (state)
          SEARCH: if (hit) begin
            expected_index <= hit_next;
            good_cnt       <= GW'(1);
            state          <= LOCK_COUNT <= 1 ? LOCKED : VERIFY;
            pattern_lock   <= LOCK_COUNT <= 1;
          end
          VERIFY: if (match) begin
            good_cnt       <= good_cnt + GW'(1);
            expected_index <= idx_next;
            if (good_cnt + GW'(1) == GW'(LOCK_COUNT)) begin
              state        <= LOCKED;
              pattern_lock <= 1'b1;
            end
          end else begin
            state    <= SEARCH;
            good_cnt <= '0;
          end
          default: begin
            expected_index <= idx_next;
            pattern_error  <= !match;
            if (!match && error_count != '1) error_count <= error_count + 1'b1;
            win_cnt <= win_wrap ? '0 : win_cnt + WW'(1);
            win_err <= win_err_nxt;
            if (win_err_nxt == EW'(UNLOCK_ERRORS)) begin
              state        <= SEARCH;
              pattern_lock <= 1'b0;
              good_cnt     <= '0;
              win_cnt      <= '0;
              win_err      <= '0;
            end
          end
        endcase
      end
      if (clear_count) error_count <= '0;
    end
endmodule

// File: tb/tb_xgmii_pattern_checker.sv
// tb_xgmii_pattern_checker: directed plus random stimulus against a word-level reference model
module tb_xgmii_pattern_checker;
  localparam int NPAT = 6, LOCKN = 4, WIN = 64, UNL = 8;
  logic        rx_clk = 1'b0, rx_rst_n = 1'b0, enable = 1'b1, rx_block_lock = 1'b1, clear_count = 1'b0;
  logic [63:0] xgmii_rxd = '0;
  logic [7:0]  xgmii_rxc = '0;
  logic        pattern_lock, pattern_error, pattern_lock_s, pattern_error_s;
  logic [15:0] error_count;
  logic [3:0]  error_count_s;
  logic [2:0]  expected_index, expected_index_s;
  xgmii_pattern_checker u_dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .enable(enable), .rx_block_lock(rx_block_lock),
    .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc), .clear_count(clear_count),
    .pattern_lock(pattern_lock), .pattern_error(pattern_error),
    .error_count(error_count), .expected_index(expected_index));
  xgmii_pattern_checker #(.ERR_CNT_WIDTH(4)) u_dut_s (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .enable(enable), .rx_block_lock(rx_block_lock),
    .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc), .clear_count(clear_count),
    .pattern_lock(pattern_lock_s), .pattern_error(pattern_error_s),
    .error_count(error_count_s), .expected_index(expected_index_s));
  always #5 rx_clk = ~rx_clk;
  logic [63:0] pat [NPAT] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h5555555555555555,
                              64'hAAAAAAAAAAAAAAAA, 64'hFEFEFEFEFEFEFEFE, 64'h0707070707070707};
  int tests = 0, fails = 0;
  int m_state, m_idx, m_good, m_wcnt, m_werr, m_c16, m_c4, tx_phase;
  bit m_lock, m_perr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("lock", 32'(pattern_lock), 32'(m_lock));
    check("perr", 32'(pattern_error), 32'(m_perr));
    check("cnt", 32'(error_count), 32'(m_c16));
    check("idx", 32'(expected_index), 32'(m_idx));
    check("lock_s", 32'(pattern_lock_s), 32'(m_lock));
    check("perr_s", 32'(pattern_error_s), 32'(m_perr));
    check("cnt_s", 32'(error_count_s), 32'(m_c4));
    check("idx_s", 32'(expected_index_s), 32'(m_idx));
  endtask
  task automatic model_reset();
    {m_state, m_idx, m_good, m_wcnt, m_werr, m_c16, m_c4} = '0;
    m_lock = 0;
    m_perr = 0;
  endtask
  function automatic bit m_match(int k);
    return xgmii_rxc == 8'h00 && xgmii_rxd == pat[k];
  endfunction
  task automatic model_step();
    int found;
    bit mis;
    m_perr = 0;
    if (!(enable && rx_block_lock)) begin
      m_state = 0; m_lock = 0; m_good = 0; m_wcnt = 0; m_werr = 0;
    end else if (m_state == 0) begin
      found = -1;
      for (int k = NPAT - 1; k >= 0; k--) if (m_match(k)) found = k;
      if (found >= 0) begin
        m_idx = (found + 1) % NPAT;
        m_good = 1;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_match(m_idx)) begin
        m_good++;
        m_idx = (m_idx + 1) % NPAT;
        if (m_good == LOCKN) begin m_state = 2; m_lock = 1; m_wcnt = 0; m_werr = 0; end
      end else begin
        m_state = 0; m_good = 0;
      end
    end else begin
      mis = !m_match(m_idx);
      m_idx = (m_idx + 1) % NPAT;
      m_perr = mis;
      if (mis && m_c16 < 65535) m_c16++;
      if (mis && m_c4 < 15) m_c4++;
      m_wcnt++;
      if (m_wcnt == WIN) begin m_wcnt = 0; m_werr = 0; end
      if (mis) m_werr++;
      if (m_werr == UNL) begin m_state = 0; m_lock = 0; m_good = 0; m_wcnt = 0; m_werr = 0; end
    end
    if (clear_count) begin m_c16 = 0; m_c4 = 0; end
  endtask
  task automatic step(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(posedge rx_clk);
    model_step();
    #1 check_all();
    @(negedge rx_clk);
  endtask
  task automatic send(input logic [63:0] mask, input logic [7:0] c);
    step(pat[tx_phase] ^ mask, c);
    tx_phase = (tx_phase + 1) % NPAT;
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) begin
      xgmii_rxd = {$urandom, $urandom};
      @(negedge rx_clk);
      check_all();
    end
    rx_rst_n = 1'b1;
    repeat (5) step(64'h1234, 8'h00);
    check("idle_nolock", 32'(pattern_lock), 32'd0);
    tx_phase = 2;
    repeat (3) send('0, '0);
    check("prelock", 32'(pattern_lock), 32'd0);
    send('0, '0);
    check("lock4", 32'(pattern_lock), 32'd1);
    repeat (200) send('0, '0);
    check("clean_cnt", 32'(error_count), 32'd0);
    while (tx_phase != 3) send('0, '0);
    send(64'h1, '0);
    check("flip_perr", 32'(pattern_error), 32'd1);
    check("flip_cnt", 32'(error_count), 32'd1);
    send('0, '0);
    check("fe_match", 32'(pattern_error), 32'd0);
    check("flip_lock", 32'(pattern_lock), 32'd1);
    rx_block_lock = 1'b0;
    clear_count = 1'b1;
    send('0, '0);
    rx_block_lock = 1'b1;
    clear_count = 1'b0;
    repeat (4) send('0, '0);
    for (int i = 0; i < 8; i++) begin
      check("garbage_lock", 32'(pattern_lock), 32'd1);
      step({$urandom, $urandom} | 64'h1, 8'h00);
    end
    check("unlock", 32'(pattern_lock), 32'd0);
    check("unlock_cnt", 32'(error_count), 32'd8);
    repeat (4) send('0, '0);
    check("relock", 32'(pattern_lock), 32'd1);
    check("relock_cnt", 32'(error_count), 32'd8);
    while (tx_phase != 5) send('0, '0);
    send('0, 8'hFF);
    check("rxc_perr", 32'(pattern_error), 32'd1);
    check("rxc_cnt", 32'(error_count), 32'd9);
    rx_block_lock = 1'b0;
    send('0, '0);
    check("blk_drop", 32'(pattern_lock), 32'd0);
    check("blk_cnt", 32'(error_count), 32'd9);
    rx_block_lock = 1'b1;
    clear_count = 1'b1;
    send('0, '0);
    clear_count = 1'b0;
    repeat (4) send('0, '0);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(10, 15)) send('0, '0);
      send(64'h1 << $urandom_range(0, 63), '0);
    end
    check("sat_s", 32'(error_count_s), 32'd15);
    check("sat_wide", 32'(error_count), 32'd20);
    check("sat_lock", 32'(pattern_lock), 32'd1);
    clear_count = 1'b1;
    send(64'h8000_0000_0000_0000, '0);
    clear_count = 1'b0;
    check("clr_cnt", 32'(error_count), 32'd0);
    check("clr_perr", 32'(pattern_error), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      enable        = $urandom_range(0, 59) != 0;
      rx_block_lock = $urandom_range(0, 59) != 0;
      clear_count   = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 199) == 0) tx_phase = $urandom_range(0, NPAT - 1);
      if ($urandom_range(0, 29) == 0) step({$urandom, $urandom}, 8'h00);
      else send($urandom_range(0, 11) == 0 ? 64'h1 << $urandom_range(0, 63) : 64'h0,
                $urandom_range(0, 39) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      if ($urandom_range(0, 499) == 0) begin
        rx_rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        rx_rst_n = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
